conv_frame_sequencer: RTL and testbench

- Sequences the 9-in / 9-out combinational transform datapath (9-bit X in; nine signed 20-bit Y_0..Y_8 out).
- Accepts 9-bit X words over a valid/ready handshake and drives the word onto the datapath input. It waits a programmable settle time, then snapshots all nine results.
- Drains the snapshot as a serial stream of signed 20-bit words with index and last flags. It sits between an upstream pattern source and a downstream single-word consumer.

---
 rtl/conv_frame_sequencer.sv | 114 +++++++++++
 tb/tb_conv_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 9-in/9-out transform datapath: accepts one X word,
// holds it on dp_x for a settle window, snapshots all nine Y results, then drains them serially.
module conv_frame_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int N_OUT         = 9,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_x,
  output logic [8:0]       dp_x,
  input  logic [179:0]     dp_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [19:0]      out_data,
  output logic [3:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(N_OUT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [8:0]        dp_x_q, dp_x_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic signed [19:0] cap_q [N_OUT];
  logic signed [19:0] cap_d [N_OUT];

  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = out_valid ? cap_q[idx_q] : '0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign busy      = (state_q != S_IDLE);
  assign dp_x      = dp_x_q;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dp_x_d      = dp_x_q;
    frame_cnt_d = frame_cnt_q;
    for (int k = 0; k < N_OUT; k++) cap_d[k] = cap_q[k];

    // flush overrides everything, including a completing last beat
    if (flush) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            dp_x_d  = in_x;
            cnt_d   = 4'(SETTLE_CYCLES);
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            for (int k = 0; k < N_OUT; k++) cap_d[k] = dp_y[20*k +: 20];
            idx_d   = 4'd0;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
              idx_d       = 4'd0;
              state_d     = S_IDLE;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= 4'd0;
      dp_x_q      <= 9'd0;
      frame_cnt_q <= '0;
      for (int k = 0; k < N_OUT; k++) cap_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dp_x_q      <= dp_x_d;
      frame_cnt_q <= frame_cnt_d;
      for (int k = 0; k < N_OUT; k++) cap_q[k] <= cap_d[k];
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: datapath stub Y_k = X*(k-4); expected beats are
// queued by the stimulus and consumed by a monitor on each output transfer.
module tb_conv_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_x;
  logic [8:0]   dp_x;
  logic [179:0] dp_y;
  logic         out_valid;
  logic         out_ready;
  logic [19:0]  out_data;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic [15:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] d;
    logic [3:0]  i;
    logic        l;
  } exp_t;
  exp_t exp_q[$];

  conv_frame_sequencer #(.SETTLE_CYCLES(2), .N_OUT(9), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .dp_x(dp_x), .dp_y(dp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    dp_y = '0;
    for (int k = 0; k < 9; k++) dp_y[20*k +: 20] = 20'($signed({11'b0, dp_x}) * (k - 4));
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_frame(input int x, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      exp_t e;
      int v;
      v   = x * (k - 4);
      e.d = v[19:0];
      e.i = 4'(k);
      e.l = (k == 8);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sx(input int v);
    logic [19:0] t;
    t = v[19:0];
    return {12'b0, t};
  endfunction

  // Monitor: a beat transfers at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat idx=%0d data=%0h required=none", out_idx, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("beat_data", {12'b0, out_data}, {12'b0, e.d});
        check("beat_idx",  {28'b0, out_idx},  {28'b0, e.i});
        check("beat_last", {31'b0, out_last}, {31'b0, e.l});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data",  {12'b0, out_data}, 0);
    check("rst_out_idx",   {28'b0, out_idx}, 0);
    check("rst_out_last",  {31'b0, out_last}, 0);
    check("rst_busy",      {31'b0, busy}, 0);
    check("rst_in_ready",  {31'b0, in_ready}, 1);
    check("rst_frame_cnt", {16'b0, frame_cnt}, 0);
    check("rst_dp_x",      {23'b0, dp_x}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single frame, X=495
    push_frame(495, 9);
    in_valid = 1'b1; in_x = 9'b111101111;
    tick();
    in_valid = 1'b0;
    check("f1_dp_x", {23'b0, dp_x}, 495);
    check("f1_busy", {31'b0, busy}, 1);
    check("f1_in_ready_settle", {31'b0, in_ready}, 0);
    check("f1_valid_e0", {31'b0, out_valid}, 0);
    tick();
    check("f1_valid_e1", {31'b0, out_valid}, 0);
    tick();
    check("f1_valid_e2", {31'b0, out_valid}, 1);
    check("f1_first_data", {12'b0, out_data}, sx(-1980));
    repeat (9) tick();
    check("f1_frame_cnt", {16'b0, frame_cnt}, 1);
    check("f1_in_ready_after", {31'b0, in_ready}, 1);
    check("f1_valid_after", {31'b0, out_valid}, 0);

    // Backpressure at idx=3, X=341
    push_frame(341, 9);
    in_valid = 1'b1; in_x = 9'b101010101;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    tick(); tick(); tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_idx",  {28'b0, out_idx}, 3);
      check("bp_data", {12'b0, out_data}, sx(-341));
      tick();
    end
    check("bp_idx_end", {28'b0, out_idx}, 3);
    out_ready = 1'b1;
    repeat (6) tick();
    check("bp_frame_cnt", {16'b0, frame_cnt}, 2);
    check("bp_busy_after", {31'b0, busy}, 0);

    // Upstream held valid during a whole frame
    push_frame(239, 9);
    in_valid = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      in_x = (n == 12) ? 9'b001010101 : ((n % 2) != 0 ? 9'b001010101 : 9'b011101111);
      if (n == 12) push_frame(85, 9);
      tick();
      if (n < 11) check("ub_in_ready_busy", {31'b0, in_ready}, 0);
      if (n == 11) begin
        check("ub_in_ready_idle", {31'b0, in_ready}, 1);
        check("ub_dp_x_first", {23'b0, dp_x}, 239);
      end
    end
    in_valid = 1'b0;
    check("ub_dp_x_second", {23'b0, dp_x}, 85);
    repeat (11) tick();
    check("ub_frame_cnt", {16'b0, frame_cnt}, 4);

    // Flush at idx=5 (beat 5 still transfers on the flush edge)
    push_frame(100, 6);
    in_valid = 1'b1; in_x = 9'd100;
    tick();
    in_valid = 1'b0; in_x = 9'd7;
    repeat (7) tick();
    check("fl5_idx", {28'b0, out_idx}, 5);
    flush = 1'b1; in_valid = 1'b1;
    tick();
    check("fl5_valid", {31'b0, out_valid}, 0);
    check("fl5_busy", {31'b0, busy}, 0);
    check("fl5_frame_cnt", {16'b0, frame_cnt}, 4);
    check("fl_idle_in_ready", {31'b0, in_ready}, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_idle_no_accept", {31'b0, busy}, 0);
    check("fl_idle_dp_x", {23'b0, dp_x}, 100);

    // Flush on the last-beat transfer
    push_frame(200, 9);
    in_valid = 1'b1; in_x = 9'd200;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("fl8_last", {31'b0, out_last}, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl8_valid", {31'b0, out_valid}, 0);
    check("fl8_frame_cnt", {16'b0, frame_cnt}, 4);
    check("fl8_out_idx", {28'b0, out_idx}, 0);

    // Async reset mid-drain at idx=4
    push_frame(300, 4);
    in_valid = 1'b1; in_x = 9'd300;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("ar_idx", {28'b0, out_idx}, 4);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 0);
    check("ar_busy", {31'b0, busy}, 0);
    check("ar_frame_cnt", {16'b0, frame_cnt}, 0);
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    push_frame(487, 9);
    in_valid = 1'b1; in_x = 9'b111100111;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    check("ar_new_frame_cnt", {16'b0, frame_cnt}, 1);

    // Counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    check("wrap_pre", {16'b0, frame_cnt}, 32'h0000FFFF);
    push_frame(1, 9);
    in_valid = 1'b1; in_x = 9'd1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    check("wrap_post", {16'b0, frame_cnt}, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
